// File: rtl/mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul32_seq_ctrl
//   Folded DW x DW multiplier. A single half-width multiplier (wallace16) is
//   time-shared over four steps. The partial products are shifted and summed
//   in a 2*DW accumulator. Ready/valid handshakes are used on both sides.
//
//   Optional feature: define MUL32_SIGNED_EN to add the sgn port. With
//   sgn=1 the operands are treated as two's complement. The build without the
//   macro is unsigned only and has no negation logic.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort back to IDLE; acc is kept
//   in_valid/in_ready   operand handshake (a, b, and sgn when enabled)
//   out_valid/out_ready product handshake; out is held while waiting
//   out                 2*DW product, registered
//   busy                operation in flight (MUL or DONE)
// ---------------------------------------------------------------------------

// Shared half-width multiplier. The compressor tree is left to synthesis.
module wallace16 #(
  parameter int W = 16
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);
  assign p = x * y;
endmodule

module mul32_seq_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
`ifdef MUL32_SIGNED_EN
  input  logic            sgn,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out,
  output logic            busy
);

  localparam int HW = DW / 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] out_q, out_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
`ifdef MUL32_SIGNED_EN
  logic            neg_q, neg_d;
  logic [DW-1:0]   a_mag, b_mag;
`endif

  logic [HW-1:0]   mx, my;
  logic [DW-1:0]   pp;
  logic [2*DW-1:0] pp_sh;
  logic [2*DW-1:0] acc_sum;
  logic [2*DW-1:0] final_val;
  logic            accept;

  wallace16 #(.W(HW)) u_mul (.x(mx), .y(my), .p(pp));

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  // clr wins over any accept, including one in IDLE.
  assign accept    = in_valid & in_ready & ~clr;

`ifdef MUL32_SIGNED_EN
  // Unsigned negation gives the magnitude; -2^(DW-1) maps onto 2^(DW-1).
  assign a_mag = (sgn & a[DW-1]) ? (~a + 1'b1) : a;
  assign b_mag = (sgn & b[DW-1]) ? (~b + 1'b1) : b;
`endif

  // Operand halves and shift selected by step: lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mx    = a_q[HW-1:0];
    my    = b_q[HW-1:0];
    pp_sh = {{DW{1'b0}}, pp};
    case (step_q)
      2'd1: begin
        mx    = a_q[DW-1:HW];
        pp_sh = {{DW{1'b0}}, pp} << HW;
      end
      2'd2: begin
        my    = b_q[DW-1:HW];
        pp_sh = {{DW{1'b0}}, pp} << HW;
      end
      2'd3: begin
        mx    = a_q[DW-1:HW];
        my    = b_q[DW-1:HW];
        pp_sh = {{DW{1'b0}}, pp} << DW;
      end
      default: ;
    endcase
    acc_sum = acc_q + pp_sh;
`ifdef MUL32_SIGNED_EN
    final_val = neg_q ? (~acc_sum + 1'b1) : acc_sum;
`else
    final_val = acc_sum;
`endif
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    out_d   = out_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef MUL32_SIGNED_EN
    neg_d   = neg_q;
`endif
    if (clr) begin
      state_d = S_IDLE;
      step_d  = 2'd0;
    end else begin
      case (state_q)
        S_MUL: begin
          acc_d  = acc_sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = S_DONE;
            out_d   = final_val;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
      // Accept is legal from IDLE and from DONE on the output handshake edge.
      if (accept) begin
        state_d = S_MUL;
        step_d  = 2'd0;
        acc_d   = '0;
`ifdef MUL32_SIGNED_EN
        a_d     = a_mag;
        b_d     = b_mag;
        neg_d   = sgn & (a[DW-1] ^ b[DW-1]);
`else
        a_d     = a;
        b_d     = b;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      acc_q   <= '0;
      out_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef MUL32_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef MUL32_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq_ctrl
//   Scoreboard bench for mul32_seq_ctrl. The monitor predicts each accept
//   from the handshake rules, pushes the product computed with plain
//   arithmetic, and pops and compares on every output handshake. The same
//   monitor tracks when out_valid is due (4 edges after the accepting edge).
// ---------------------------------------------------------------------------
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  always #5 clk = ~clk;

  mul32_seq_ctrl #(.DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MUL32_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product straight from the arithmetic definition.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    logic        [63:0] r;
    r = {32'd0, x} * {32'd0, y};
`ifdef MUL32_SIGNED_EN
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      r  = sx * sy;
    end
`else
    sx = '0;
    sy = '0;
    if (s) r = r + sx + sy;
`endif
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [63:0] expq[$];
  bit          pending = 0;
  int          since   = 0;
  bit          exp_valid, exp_ready;
  bit          held = 0;
  logic [63:0] held_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      held    = 0;
      expq.delete();
    end else begin
      if (pending) since++;
      exp_valid = pending && (since >= 4);
      exp_ready = !pending || (exp_valid && out_ready);
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      check("busy", {63'd0, busy}, {63'd0, pending});
      if (held && exp_valid) check("out_stable", out, held_out);
      held     = exp_valid && !out_ready;
      held_out = out;
      if (clr) begin
        pending = 0;
        expq.delete();
      end else begin
        if (exp_valid && out_ready) begin
          if (expq.size() == 0) check("product_unexpected", out, 64'hx);
          else check("product", out, expq.pop_front());
          pending = 0;
        end
        if (in_valid && exp_ready) begin
          expq.push_back(model(a, b, sgn));
          pending = 1;
          since   = -1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                      input bit keep, output int acc_cyc);
    bit ok = 0;
    a = av; b = bv; sgn = sv; in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !clr) begin ok = 1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (!pending && expq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0, c1, c2;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sgn = 1'b0;

    // 1: reset values, held for three idle cycles after release
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out", out, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(3);
    check("idle_out", out, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // 2: all-ones operands, single-cycle out_valid
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, c0);
    wait_idle();
    check("t2_out_const", out, 64'hFFFF_FFFE_0000_0001);

    // 3: output stall; in_valid during stall is ignored
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, c0);
    for (int i = 0; i < 20 && !out_valid; i++) cycles(1);
    a = 32'd7; b = 32'd9; in_valid = 1'b1;
    cycles(3);
    check("t3_out_const", out, 64'h0B00_EA4E_242D_2080);
    out_ready = 1'b1;
    send(32'd7, 32'd9, 1'b0, 0, c0);
    wait_idle();

    // 4: back-to-back with in_valid held, five-cycle spacing
    send(32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 1, c0);
    send(32'h8000_0000, 32'h8000_0001, 1'b0, 1, c1);
    send(32'h0001_0000, 32'hFFFF_0000, 1'b0, 0, c2);
    check("b2b_space1", 64'(c1 - c0), 64'd5);
    check("b2b_space2", 64'(c2 - c1), 64'd5);
    wait_idle();

    // 5: abort on the step-2 edge, then 3*5
    send(32'hCAFE_F00D, 32'h1357_9BDF, 1'b0, 0, c0);
    cycles(2);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("clr_in_ready", {63'd0, in_ready}, 64'd1);
    check("clr_out_valid", {63'd0, out_valid}, 64'd0);
    send(32'd3, 32'd5, 1'b0, 0, c0);
    wait_idle();
    check("clr_then_15", out, 64'd15);

    // 6: 0xFFFFFFFE * 3, signed when the feature is built in
    send(32'hFFFF_FFFE, 32'd3, 1'b1, 0, c0);
    wait_idle();
`ifdef MUL32_SIGNED_EN
    check("t6_out_const", out, 64'hFFFF_FFFF_FFFF_FFFA);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 0, c0);
    wait_idle();
`else
    check("t6_out_const", out, 64'h0000_0002_FFFF_FFFA);
`endif

    // mid-operation reset: immediate reset values, nothing emitted
    send(32'h1111_2222, 32'h3333_4444, 1'b0, 0, c0);
    cycles(2);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mrst_out", out, 64'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(2);

    // random traffic with random back-pressure
    for (int n = 0; n < 30; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 0, c0);
      for (int k = 0; k < 8; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        cycles(1);
      end
    end
    out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
